// File: rtl/areg_rx.sv
// -----------------------------------------------------------------------------
// areg_rx -- serial-to-parallel receiver for the areg shift stream.
//
// Collects WIDTH serial bits into one parallel word and presents it on a
// valid/ready output backed by a single holding register. A completed word
// that arrives while the holding register is still full and not being
// consumed is dropped and reported through the sticky ovf flag. A sync mark
// that arrives in the middle of a word discards the partial word, restarts
// collection with the marked bit, and is reported through the sticky ferr
// flag.
//
// Parameters:
//   WIDTH     word width in bits (2..16)
//   MSB_FIRST 0: first received bit lands in q[0]; 1: it lands in q[WIDTH-1]
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous active-high reset
//   sin      serial data bit
//   sin_vld  sin is sampled this cycle
//   sync     with sin_vld: this bit is the first bit of a new word
//   q        received parallel word (registered)
//   q_vld    q holds an unconsumed word
//   q_rdy    consumer takes q when q_vld && q_rdy
//   busy     a partial word is in progress
//   bcnt     number of bits of the current partial word received
//   ovf      sticky: a completed word was dropped
//   ferr     sticky: a partial word was discarded by sync
//   clr_err  clears ovf and ferr (a coinciding error event wins)
// -----------------------------------------------------------------------------
module areg_rx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sin,
    input  logic                       sin_vld,
    input  logic                       sync,
    output logic [WIDTH-1:0]           q,
    output logic                       q_vld,
    input  logic                       q_rdy,
    output logic                       busy,
    output logic [$clog2(WIDTH):0]     bcnt,
    output logic                       ovf,
    output logic                       ferr,
    input  logic                       clr_err
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam logic [BW-1:0] LAST_IDX = BW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t            state_r;
    logic [WIDTH-1:0]  sr_r;
    logic [WIDTH-1:0]  q_r;
    logic [BW-1:0]     bcnt_r;
    logic              q_vld_r;
    logic              ovf_r;
    logic              ferr_r;

    logic [WIDTH-1:0]  sr_next_s;
    logic              complete_s;
    logic              drop_s;
    logic              ferr_evt_s;

    // Next shift-register value and the event decode for this cycle.
    // The shift register always takes the incoming bit; stale bits from a
    // discarded partial word are pushed out before the word can complete,
    // so a sync restart needs no explicit clear.
    always_comb begin
        sr_next_s  = sr_r;
        complete_s = 1'b0;
        drop_s     = 1'b0;
        ferr_evt_s = 1'b0;
        if (MSB_FIRST) begin
            sr_next_s = {sr_r[WIDTH-2:0], sin};
        end else begin
            sr_next_s = {sin, sr_r[WIDTH-1:1]};
        end
        if ((state_r == ST_COLLECT) && sin_vld) begin
            ferr_evt_s = sync;
            complete_s = !sync && (bcnt_r == LAST_IDX);
        end else begin
            ferr_evt_s = 1'b0;
            complete_s = 1'b0;
        end
        drop_s = complete_s && q_vld_r && !q_rdy;
    end

    // Collection FSM, holding register and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            sr_r    <= '0;
            bcnt_r  <= '0;
            q_r     <= '0;
            q_vld_r <= 1'b0;
            ovf_r   <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            if (sin_vld) begin
                sr_r <= sr_next_s;
            end

            case (state_r)
                ST_IDLE: begin
                    // sync is meaningless here: any bit starts a word
                    if (sin_vld) begin
                        bcnt_r  <= BW'(1);
                        state_r <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (sin_vld) begin
                        if (sync) begin
                            bcnt_r <= BW'(1);
                        end else if (bcnt_r == LAST_IDX) begin
                            bcnt_r  <= '0;
                            state_r <= ST_IDLE;
                        end else begin
                            bcnt_r <= bcnt_r + BW'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    bcnt_r  <= '0;
                end
            endcase

            // A completion may refill the register in the same cycle the
            // consumer drains it; otherwise a drain just clears q_vld.
            if (complete_s && !drop_s) begin
                q_r     <= sr_next_s;
                q_vld_r <= 1'b1;
            end else if (!complete_s && q_vld_r && q_rdy) begin
                q_vld_r <= 1'b0;
            end

            // Set has priority over clear on both sticky flags.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (clr_err) begin
                ovf_r <= 1'b0;
            end

            if (ferr_evt_s) begin
                ferr_r <= 1'b1;
            end else if (clr_err) begin
                ferr_r <= 1'b0;
            end
        end
    end

    assign q     = q_r;
    assign q_vld = q_vld_r;
    assign busy  = (state_r == ST_COLLECT);
    assign bcnt  = bcnt_r;
    assign ovf   = ovf_r;
    assign ferr  = ferr_r;

endmodule

// File: tb/tb_areg_rx.sv
// -----------------------------------------------------------------------------
// tb_areg_rx -- self-checking bench for areg_rx.
// Two instances (LSB-first and MSB-first) share one stimulus stream; a
// queue-based reference model predicts both every cycle.
// -----------------------------------------------------------------------------
module tb_areg_rx;

    localparam int WIDTH = 4;
    localparam int BW    = $clog2(WIDTH) + 1;
    localparam int OW    = WIDTH + BW + 4;

    logic clk = 1'b0;
    logic reset, sin, sin_vld, sync, q_rdy, clr_err;

    logic [WIDTH-1:0] q_l, q_m;
    logic             q_vld_l, q_vld_m, busy_l, busy_m, ovf_l, ovf_m, ferr_l, ferr_m;
    logic [BW-1:0]    bcnt_l, bcnt_m;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit               m_bits[$];
    int               m_cnt;
    logic [WIDTH-1:0] m_ql, m_qm;
    logic             m_qvld, m_ovf, m_ferr;

    logic [2*OW-1:0] obs, exp_v;

    areg_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset), .sin(sin), .sin_vld(sin_vld), .sync(sync),
        .q(q_l), .q_vld(q_vld_l), .q_rdy(q_rdy), .busy(busy_l), .bcnt(bcnt_l),
        .ovf(ovf_l), .ferr(ferr_l), .clr_err(clr_err)
    );

    areg_rx #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset), .sin(sin), .sin_vld(sin_vld), .sync(sync),
        .q(q_m), .q_vld(q_vld_m), .q_rdy(q_rdy), .busy(busy_m), .bcnt(bcnt_m),
        .ovf(ovf_m), .ferr(ferr_m), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    assign obs   = {q_l, q_vld_l, busy_l, bcnt_l, ovf_l, ferr_l,
                    q_m, q_vld_m, busy_m, bcnt_m, ovf_m, ferr_m};
    assign exp_v = {m_ql, m_qvld, (m_cnt != 0), BW'(m_cnt), m_ovf, m_ferr,
                    m_qm, m_qvld, (m_cnt != 0), BW'(m_cnt), m_ovf, m_ferr};

    // Reference: a word is the list of bits received since it started.
    task automatic model_update();
        bit               done;
        bit               evt_o;
        bit               evt_f;
        logic [WIDTH-1:0] wl, wm;
        done = 1'b0; evt_o = 1'b0; evt_f = 1'b0; wl = '0; wm = '0;
        if (reset) begin
            m_bits.delete();
            m_ql = '0; m_qm = '0; m_qvld = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
        end else begin
            if (sin_vld) begin
                if (sync && m_bits.size() != 0) begin
                    evt_f = 1'b1;
                    m_bits.delete();
                end
                m_bits.push_back(sin);
                if (m_bits.size() == WIDTH) begin
                    done = 1'b1;
                    for (int i = 0; i < WIDTH; i++) begin
                        wl[i]           = m_bits[i];
                        wm[WIDTH-1-i]   = m_bits[i];
                    end
                    m_bits.delete();
                end
            end
            if (done) begin
                if (m_qvld && !q_rdy) begin
                    evt_o = 1'b1;
                end else begin
                    m_ql = wl; m_qm = wm; m_qvld = 1'b1;
                end
            end else if (m_qvld && q_rdy) begin
                m_qvld = 1'b0;
            end
            if (evt_o) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
            if (evt_f) m_ferr = 1'b1; else if (clr_err) m_ferr = 1'b0;
        end
        m_cnt = m_bits.size();
    endtask

    // One clock: drive inputs, advance the model at the edge, settle.
    task automatic step(input bit r, input bit v, input bit s, input bit d,
                        input bit rdy, input bit clr);
        reset = r; sin_vld = v; sync = s; sin = d; q_rdy = rdy; clr_err = clr;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) step(1'b1, 1'(i % 2), 1'b0, 1'b1, 1'b0, 1'b0);
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_zero got=%h exp=%h", obs, {2*OW{1'b0}});
        end
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL reset_model got=%h exp=%h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        bits = 8'b0011_1010;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, bits[i], 1'b1, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL b2b_model bit=%0d got=%h exp=%h", i, obs, exp_v);
            end
            n_vec++;
            if (busy_l !== (i % 4 != 3)) begin
                n_err++;
                $display("FAIL b2b_busy bit=%0d got=%b exp=%b", i, busy_l, (i % 4 != 3));
            end
            if (i == 3) begin
                n_vec++;
                if ({q_l, q_m, q_vld_l} !== {4'b1010, 4'b0101, 1'b1}) begin
                    n_err++;
                    $display("FAIL b2b_word1 got=%b_%b_%b exp=1010_0101_1", q_l, q_m, q_vld_l);
                end
            end
            if (i == 7) begin
                n_vec++;
                if ({q_l, q_vld_l} !== {4'b0011, 1'b1}) begin
                    n_err++;
                    $display("FAIL b2b_word2 got=%b_%b exp=0011_1", q_l, q_vld_l);
                end
            end
        end
    endtask

    task automatic test_gapped();
        logic [3:0] bits;
        bits = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, bits[i], 1'b1, 1'b0);
            for (int g = 0; g < 3; g++) begin
                n_vec++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL gap_model bit=%0d idle=%0d got=%h exp=%h", i, g, obs, exp_v);
                end
                if (i < 3) begin
                    n_vec++;
                    if (bcnt_l !== BW'(i + 1)) begin
                        n_err++;
                        $display("FAIL gap_bcnt bit=%0d got=%0d exp=%0d", i, bcnt_l, i + 1);
                    end
                end
                if (i < 3) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            end
        end
        n_vec++;
        if ({q_l, q_vld_l} !== {4'b1001, 1'b1}) begin
            n_err++;
            $display("FAIL gap_word got=%b_%b exp=1001_1", q_l, q_vld_l);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] words;
        words = 8'b0101_1111;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);     // drain
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 8; i++)
                step(1'b0, 1'b1, 1'b0, words[i], (pass == 1 && i == 7), 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL ovf_model pass=%0d got=%h exp=%h", pass, obs, exp_v);
            end
            if (pass == 0) begin
                n_vec++;
                if ({q_l, q_vld_l, ovf_l} !== {4'b1111, 1'b1, 1'b1}) begin
                    n_err++;
                    $display("FAIL ovf_drop got=%b_%b_%b exp=1111_1_1", q_l, q_vld_l, ovf_l);
                end
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
                n_vec++;
                if (q_vld_l !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_accept got=%b exp=0", q_vld_l);
                end
                step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                n_vec++;
                if (ovf_l !== 1'b0) begin
                    n_err++;
                    $display("FAIL ovf_clear got=%b exp=0", ovf_l);
                end
            end else begin
                n_vec++;
                if ({q_l, q_vld_l, ovf_l} !== {4'b0101, 1'b1, 1'b0}) begin
                    n_err++;
                    $display("FAIL ovf_samecycle got=%b_%b_%b exp=0101_1_0", q_l, q_vld_l, ovf_l);
                end
            end
        end
    endtask

    task automatic test_sync();
        logic [5:0] bits;
        bits = 6'b011_011;   // sequence 1,1,0,1,1,0 (sync on the third)
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, (i == 2), bits[i], 1'b1, 1'b0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL sync_model bit=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        n_vec++;
        if ({q_l, ferr_l} !== {4'b0110, 1'b1}) begin
            n_err++;
            $display("FAIL sync_word got=%b_%b exp=0110_1", q_l, ferr_l);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 1'b1, 1'b0);
        n_vec++;
        if ({ferr_l, q_l} !== {1'b0, 4'b1111}) begin
            n_err++;
            $display("FAIL sync_idle got=%b_%b exp=0_1111", ferr_l, q_l);
        end
        // sync mid-word coinciding with clr_err: set wins
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({ferr_l, bcnt_l} !== {1'b1, BW'(1)} || obs !== exp_v) begin
            n_err++;
            $display("FAIL sync_setwins got=%b_%0d exp=1_1", ferr_l, bcnt_l);
        end
    endtask

    task automatic test_reset_midword();
        logic [3:0] bits;
        bits = 4'b1001;
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, bits[i], 1'b1, 1'b0);
        n_vec++;
        if ({q_l, q_vld_l, ferr_l, ovf_l} !== {4'b1001, 1'b1, 1'b0, 1'b0} || obs !== exp_v) begin
            n_err++;
            $display("FAIL rst_mid got=%b_%b_%b_%b exp=1001_1_0_0", q_l, q_vld_l, ferr_l, ovf_l);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            n_vec++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL rand_model cyc=%0d got=%h exp=%h", c, obs, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1; sin = 1'b0; sin_vld = 1'b0; sync = 1'b0; q_rdy = 1'b0; clr_err = 1'b0;
        m_ql = '0; m_qm = '0; m_qvld = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0; m_cnt = 0;
        test_reset();
        test_back_to_back();
        test_gapped();
        test_overflow();
        test_sync();
        test_reset_midword();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/areg_rx.md
Name: areg_rx

Overview:
- Serial-to-parallel receiver for the areg shift stream: collects WIDTH serial bits (LSB first by default) into one parallel word.
- Presents the word on a valid/ready output with one holding register.
- Sits on the far end of a serial link driven by areg in shift mode, feeding a downstream parallel consumer.
- Flags dropped words (overflow) and truncated words (framing error).

Parameters:
- WIDTH, 4, word width in bits; legal range 2..16.
- MSB_FIRST, 0, 0 means the first received bit lands in q[0]; 1 means the first received bit lands in q[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- sin  input  1  serial data bit
- sin_vld  input  1  sin is sampled on this cycle
- sync  input  1  qualified by sin_vld; marks this bit as the first bit of a new word
- q  output  WIDTH  received parallel word
- q_vld  output  1  q holds an unconsumed word
- q_rdy  input  1  consumer accepts q when q_vld && q_rdy
- busy  output  1  a partial word is in progress (state COLLECT)
- bcnt  output  clog2(WIDTH)+1  number of bits of the current partial word received
- ovf  output  1  sticky: a completed word was dropped
- ferr  output  1  sticky: a partial word was discarded by sync
- clr_err  input  1  clears ovf and ferr

Behaviour:
- Reset (synchronous, highest priority): state=IDLE, shift reg=0, bcnt=0, q=0, q_vld=0, busy=0, ovf=0, ferr=0. Reset mid-word discards the partial word with no flag.
- Internal shift reg sr[WIDTH-1:0]:
  - MSB_FIRST=0: on accepted bit, sr <= {sin, sr[WIDTH-1:1]}.
  - MSB_FIRST=1: on accepted bit, sr <= {sr[WIDTH-2:0], sin}.
- FSM states: IDLE, COLLECT.
  - IDLE, sin_vld=1: shift in, bcnt=1, go to COLLECT. sync is irrelevant in IDLE, and ferr is not set.
  - COLLECT, sin_vld=0: hold everything.
  - COLLECT, sin_vld=1, sync=1: set ferr. Restart with this bit as bit 0 (sr takes the bit, bcnt=1). Stay in COLLECT.
  - COLLECT, sin_vld=1, sync=0, bcnt<WIDTH-1: shift in, bcnt++.
  - COLLECT, sin_vld=1, sync=0, bcnt==WIDTH-1: word completes, bcnt=0, go to IDLE. The completed word is sr shifted with the current bit.
- Output register on completion:
  - If q_vld==0, or q_vld && q_rdy in the same cycle: q <= completed word, q_vld <= 1, no ovf.
  - Else (q_vld && !q_rdy): the completed word is dropped, q is unchanged, ovf <= 1.
- Latency: q/q_vld update on the clock edge that samples the last bit, so they are visible the cycle after the last sin_vld.
- Back-to-back words need no dead cycle: a bit in IDLE the cycle after completion starts the next word.
- q_vld clears on q_vld && q_rdy when no completion occurs in the same cycle. q holds its value after consumption.
- clr_err: ovf/ferr <= 0. If an error event coincides with clr_err, the flag ends up set (set wins).
- busy = (state==COLLECT). bcnt never exceeds WIDTH-1 as a visible value.
- No combinational path from any input to any output; all outputs are registered.

Test Plan (WIDTH=4, MSB_FIRST=0 unless stated):
1. Reset: hold reset 2 cycles with sin_vld toggling -> q=0000, q_vld=0, busy=0, bcnt=0, ovf=0, ferr=0.
2. Back-to-back words: q_rdy=1; bits 0,1,0,1 on 4 consecutive cycles, then 1,1,0,0 immediately after. Expect:
   - q=1010 with q_vld=1 the cycle after the 4th bit;
   - q=0011 four cycles later;
   - busy=1 only during bits 2-4 of each word.
   - With MSB_FIRST=1, the same first word gives q=0101.
3. Gapped input: bits 1,0,0,1 with 3 idle cycles between each -> bcnt steps 1,2,3, then q=1001, q_vld=1. No change occurs on idle cycles.
4. Overflow and accept:
   - q_rdy=0; send words 1111, then 0101 -> q=1111 and q_vld=1 held, ovf=1.
   - Raise q_rdy one cycle -> q_vld=0.
   - Pulse clr_err -> ovf=0.
   - Repeat with q_rdy=1 on the completing cycle of the second word -> q=0101, q_vld stays 1, ovf=0.
5. Sync mid-word: bits 1,1, then sync=1 with bit 0, then 1,1,0 -> ferr=1, q=0110. A sync on the first bit of a word in IDLE leaves ferr=0.
6. Reset mid-word: bits 1,1 then reset for 1 cycle, then 1,0,0,1 -> q=1001 with no residue, ferr=0, ovf=0.
